target_round_scheduler: RTL and testbench
=========================================

Name: target_round_scheduler

Overview:
- Hardware game sequencer for the two-target shooting game.
- Arms two target slots (A, B) from the random-number stream and runs an independent timeout per slot.
- Detects hits from the photodiode array and accumulates score and misses until the game timer expires.
- Drives target select lines and the score bus that feed the score converter and target LEDs, replacing the software game loop.

Parameters:
- NUM_TARGETS, 10, number of photodiode targets; valid indices 0..NUM_TARGETS-1.
- TARGET_TIMEOUT, 50000000, cycles a slot stays armed before counting a miss.
- GAME_CYCLES, 1500000000, game length in cycles; 32-bit counter.
- HIT_POINTS, 1, score added per hit.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_game  in  1  level; sampled in IDLE and GAME_OVER.
- rand_num  in  4  random value, new value every cycle.
- photo_array  in  10  asynchronous photodiode hit lines, active-high.
- target_a  out  4  slot A target index; 4'hF = none.
- target_b  out  4  slot B target index; 4'hF = none.
- score  out  32  accumulated score.
- misses  out  16  timeout count, saturating at 16'hFFFF.
- game_active  out  1  high in PICK/ARMED states.
- game_over  out  1  high in GAME_OVER.
- hit_pulse_a  out  1  one-cycle pulse on a slot A hit.
- hit_pulse_b  out  1  one-cycle pulse on a slot B hit.

Behaviour:
- Reset: all of the following hold from the edge reset is sampled high, regardless of state:
  - target_a = target_b = 4'hF; score = 0; misses = 0.
  - game_active = 0; game_over = 0; hit pulses = 0.
  - Game and slot counters = 0; state = IDLE.
  - Synchronizer flops cleared.
- Input synchronization: photo_array passes through a 2-flop synchronizer; hit logic uses only the synchronized bits.
- Global FSM:
  - IDLE -> RUN on start_game=1. Clears score, misses and game counter; both slots go to PICK.
  - RUN -> GAME_OVER when the game counter reaches GAME_CYCLES-1. The counter increments every RUN cycle.
  - GAME_OVER: targets = 4'hF; score and misses held; game_over=1. -> RUN on start_game=1, with the same clears as from IDLE.
- Per-slot FSM (runs only in RUN):
  - PICK: accept rand_num only if all of these hold:
    - rand_num < NUM_TARGETS;
    - rand_num != the other slot's current target;
    - rand_num != this slot's previous target.
    - If the value is rejected, retry next cycle; target output stays 4'hF while picking.
  - Accept: the target register loads on the edge; the slot timeout counter clears; -> ARMED.
  - Simultaneous pick conflict: if both slots are in PICK and would accept the same value, slot A wins and slot B retries.
  - ARMED, hit: synchronized photo_array[target]=1 -> hit_pulse for 1 cycle; score += HIT_POINTS; -> PICK.
  - ARMED, timeout: counter reaches TARGET_TIMEOUT-1 with no hit -> misses += 1 (saturating); -> PICK.
  - Hit and timeout in the same cycle: the hit wins.
- Both slots hit in the same cycle: score += 2*HIT_POINTS in one update; both pulses fire.
- Hit latency: photo line held high before edge N -> score and pulse updated at edge N+2, visible after edge N+2.
- Game end mid-ARMED: the pending slot is discarded; no score or miss is recorded for it.
- Score arithmetic: 32-bit unsigned, wraps modulo 2^32. misses saturates.
- Target lines whose target is not armed are ignored.
- A line held high across a re-pick cannot re-hit, because the new target is always a different index.

Optional Feature:
- Macro COMBO_BONUS_EN.
- Defined:
  - Adds an internal 8-bit streak counter, incremented on each hit and cleared on each timeout miss.
  - Each hit that brings the streak to a multiple of 5 adds an extra 5 points in the same update.
  - For a dual hit, the streak advances by 2; the bonus applies once if any multiple of 5 is crossed.
  - The streak clears on game start and reset.
- Undefined: flat HIT_POINTS scoring; no streak logic.

Test Plan:
- Reset priority: reset during RUN with score=7 -> next edge score=0, targets=4'hF, game_active=0.
- Pick filtering:
  - Stimulus: NUM_TARGETS=10, TARGET_TIMEOUT=20; start_game; rand_num sequence 12, 15, 3.
  - Response: slot A arms target 3 on the third cycle. Slot B then rejects 3 and arms the next valid value, e.g. 7.
- Hit path: target_a=3 armed; pulse photo_array[3] high for 3 cycles -> hit_pulse_a one cycle, score 0->1 two edges after the first sampled high, slot A re-picks a value !=3 and !=target_b.
- Timeout: no hits with TARGET_TIMEOUT=20 -> each slot increments misses every 20 armed cycles plus its pick time; a hit landing on the timeout cycle counts as a hit.
- Dual hit: both targets' lines high in the same cycle -> score += 2; both pulses fire.
- Game end: GAME_CYCLES=1000 -> game_over asserts after 1000 RUN cycles; targets=4'hF; score frozen; start_game restarts from score 0.
- COMBO_BONUS_EN: 5 consecutive hits -> score=10; a timeout then 5 more hits -> score=20.

Source files
------------

// File: rtl/target_round_scheduler.sv
// target_round_scheduler: two-slot shooting-game sequencer (pick, arm, hit/timeout, score).
// Build option COMBO_BONUS_EN: 8-bit hit streak adding 5 bonus points on each multiple of 5.
module target_round_scheduler #(
   parameter int NUM_TARGETS    = 10,
   parameter int TARGET_TIMEOUT = 50000000,
   parameter int GAME_CYCLES    = 1500000000,
   parameter int HIT_POINTS     = 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start_game,
   input  logic [3:0]             rand_num,
   input  logic [NUM_TARGETS-1:0] photo_array,
   output logic [3:0]             target_a,
   output logic [3:0]             target_b,
   output logic [31:0]            score,
   output logic [15:0]            misses,
   output logic                   game_active,
   output logic                   game_over,
   output logic                   hit_pulse_a,
   output logic                   hit_pulse_b
);

   typedef enum logic [1:0] {G_IDLE, G_RUN, G_OVER} game_state_t;
   typedef enum logic {S_PICK, S_ARMED} slot_state_t;

   localparam int            TW        = $clog2(TARGET_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TARGET_TIMEOUT - 1);
   localparam logic [31:0]   GAME_LAST = 32'(GAME_CYCLES - 1);
   localparam logic [3:0]    NONE      = 4'hF;

   function automatic logic [15:0] sat_add_misses(input logic [15:0] base, input logic [1:0] inc);
      logic [16:0] sum;
      sum = {1'b0, base} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   game_state_t             game_state, game_state_n;
   slot_state_t             slot_a, slot_a_n, slot_b, slot_b_n;
   logic [3:0]              cur_a, cur_a_n, cur_b, cur_b_n;
   logic [3:0]              prev_a, prev_a_n, prev_b, prev_b_n;
   logic [TW-1:0]           age_a, age_a_n, age_b, age_b_n;
   logic [31:0]             game_cnt, game_cnt_n;
   logic [31:0]             score_n, add_pts;
   logic [15:0]             misses_n;
   logic [NUM_TARGETS-1:0]  photo_s1, photo_s2;
   logic [15:0]             photo_pad;
   logic [1:0]              nhits;
   logic                    run, start_clr, rand_ok;
   logic [3:0]              tgt_a, tgt_b;
   logic                    acc_a, acc_b, hit_a, hit_b, tmo_a, tmo_b;

`ifdef COMBO_BONUS_EN
   logic [7:0] streak, streak_n, streak_up;

   function automatic logic combo_bonus(input logic [7:0] streak_new, input logic [1:0] hits);
      logic [7:0] one_back;
      one_back = streak_new - 8'd1;
      return (hits != 2'd0 && (streak_new % 8'd5) == 8'd0) ||
             (hits == 2'd2 && (one_back % 8'd5) == 8'd0);
   endfunction
`endif

   // Hit indexing uses a 16-bit view so an index of 4'hF can never select past the array
   assign photo_pad = 16'(photo_s2);

   always_comb begin
      run       = (game_state == G_RUN);
      start_clr = (game_state != G_RUN) && start_game;
      tgt_a     = (run && slot_a == S_ARMED) ? cur_a : NONE;
      tgt_b     = (run && slot_b == S_ARMED) ? cur_b : NONE;
      rand_ok   = ({28'd0, rand_num} < 32'(NUM_TARGETS));
      acc_a     = run && slot_a == S_PICK && rand_ok && rand_num != tgt_b && rand_num != prev_a;
      acc_b     = run && slot_b == S_PICK && rand_ok && rand_num != tgt_a && rand_num != prev_b && !acc_a;
      hit_a     = run && slot_a == S_ARMED && photo_pad[cur_a];
      hit_b     = run && slot_b == S_ARMED && photo_pad[cur_b];
      tmo_a     = run && slot_a == S_ARMED && !hit_a && age_a == TMO_LAST;
      tmo_b     = run && slot_b == S_ARMED && !hit_b && age_b == TMO_LAST;
      nhits     = {1'b0, hit_a} + {1'b0, hit_b};
      add_pts   = '0;
      if (hit_a) add_pts = add_pts + 32'(HIT_POINTS);
      if (hit_b) add_pts = add_pts + 32'(HIT_POINTS);
`ifdef COMBO_BONUS_EN
      streak_up = streak + {6'd0, nhits};
      streak_n  = streak;
      if (combo_bonus(streak_up, nhits)) add_pts = add_pts + 32'd5;
      if (start_clr)              streak_n = '0;
      else if (run)               streak_n = (tmo_a || tmo_b) ? 8'd0 : streak_up;
`endif

      game_state_n = game_state;
      game_cnt_n   = game_cnt;
      score_n      = score;
      misses_n     = misses;
      slot_a_n     = slot_a;
      slot_b_n     = slot_b;
      cur_a_n      = cur_a;
      cur_b_n      = cur_b;
      prev_a_n     = prev_a;
      prev_b_n     = prev_b;
      age_a_n      = age_a;
      age_b_n      = age_b;

      case (game_state)
         G_IDLE, G_OVER: if (start_game) game_state_n = G_RUN;
         G_RUN:          if (game_cnt == GAME_LAST) game_state_n = G_OVER;
         default:        game_state_n = G_IDLE;
      endcase

      if (start_clr) begin
         game_cnt_n = '0;
         score_n    = '0;
         misses_n   = '0;
         slot_a_n   = S_PICK;
         slot_b_n   = S_PICK;
         cur_a_n    = NONE;
         cur_b_n    = NONE;
         prev_a_n   = NONE;
         prev_b_n   = NONE;
         age_a_n    = '0;
         age_b_n    = '0;
      end else if (run) begin
         game_cnt_n = game_cnt + 32'd1;
         score_n    = score + add_pts;
         misses_n   = sat_add_misses(misses, {1'b0, tmo_a} + {1'b0, tmo_b});
         if (acc_a) begin
            slot_a_n = S_ARMED;
            cur_a_n  = rand_num;
            age_a_n  = '0;
         end else if (slot_a == S_ARMED) begin
            if (hit_a || tmo_a) begin
               slot_a_n = S_PICK;
               prev_a_n = cur_a;
            end else begin
               age_a_n = age_a + TW'(1);
            end
         end
         if (acc_b) begin
            slot_b_n = S_ARMED;
            cur_b_n  = rand_num;
            age_b_n  = '0;
         end else if (slot_b == S_ARMED) begin
            if (hit_b || tmo_b) begin
               slot_b_n = S_PICK;
               prev_b_n = cur_b;
            end else begin
               age_b_n = age_b + TW'(1);
            end
         end
      end
   end

   // State, score and synchronizer registers
   always_ff @(posedge clock) begin
      if (reset) begin
         game_state  <= G_IDLE;
         game_cnt    <= '0;
         score       <= '0;
         misses      <= '0;
         slot_a      <= S_PICK;
         slot_b      <= S_PICK;
         cur_a       <= NONE;
         cur_b       <= NONE;
         prev_a      <= NONE;
         prev_b      <= NONE;
         age_a       <= '0;
         age_b       <= '0;
         hit_pulse_a <= 1'b0;
         hit_pulse_b <= 1'b0;
         photo_s1    <= '0;
         photo_s2    <= '0;
`ifdef COMBO_BONUS_EN
         streak      <= '0;
`endif
      end else begin
         game_state  <= game_state_n;
         game_cnt    <= game_cnt_n;
         score       <= score_n;
         misses      <= misses_n;
         slot_a      <= slot_a_n;
         slot_b      <= slot_b_n;
         cur_a       <= cur_a_n;
         cur_b       <= cur_b_n;
         prev_a      <= prev_a_n;
         prev_b      <= prev_b_n;
         age_a       <= age_a_n;
         age_b       <= age_b_n;
         hit_pulse_a <= hit_a;
         hit_pulse_b <= hit_b;
         photo_s1    <= photo_array;
         photo_s2    <= photo_s1;
`ifdef COMBO_BONUS_EN
         streak      <= streak_n;
`endif
      end
   end

   assign target_a    = tgt_a;
   assign target_b    = tgt_b;
   assign game_active = run;
   assign game_over   = (game_state == G_OVER);

endmodule

// File: tb/tb_target_round_scheduler.sv
// Scoreboard bench for target_round_scheduler: random stimulus, behavioural game model, queued expectations.
module tb_target_round_scheduler;
   localparam int NT   = 10;
   localparam int TO   = 20;
   localparam int GC   = 1000;
   localparam int HP   = 1;
   localparam int NCYC = 3400;

   logic          clock = 1'b0;
   logic          reset, start_game;
   logic [3:0]    rand_num;
   logic [NT-1:0] photo_array;
   logic [3:0]    target_a, target_b;
   logic [31:0]   score;
   logic [15:0]   misses;
   logic          game_active, game_over, hit_pulse_a, hit_pulse_b;

   always #5 clock = ~clock;

   target_round_scheduler #(
      .NUM_TARGETS(NT), .TARGET_TIMEOUT(TO), .GAME_CYCLES(GC), .HIT_POINTS(HP)
   ) dut (
      .clock(clock), .reset(reset), .start_game(start_game), .rand_num(rand_num),
      .photo_array(photo_array), .target_a(target_a), .target_b(target_b),
      .score(score), .misses(misses), .game_active(game_active), .game_over(game_over),
      .hit_pulse_a(hit_pulse_a), .hit_pulse_b(hit_pulse_b)
   );

   typedef struct packed {
      logic [3:0]  ta;
      logic [3:0]  tb;
      logic [31:0] sc;
      logic [15:0] mi;
      logic        act;
      logic        ov;
      logic        pa;
      logic        pb;
   } snap_t;

   snap_t exp_q[$];
   int    cyc_q[$];
   int    checks = 0;
   int    failures = 0;

   // Game model: phase 0 = waiting for start, 1 = playing, 2 = finished
   int            m_phase, m_elapsed, m_score, m_misses;
   bit            m_armed[2];
   bit            m_pulse[2];
   int            m_tgt[2], m_age[2], m_prev[2];
   logic [NT-1:0] m_hist[$];
   int            hold_n[2], hold_i[2];

   function automatic int shown(input int s);
      return (m_phase == 1 && m_armed[s]) ? m_tgt[s] : 15;
   endfunction

   task automatic model_edge(input bit r, input bit sg, input int rn, input logic [NT-1:0] ph);
      logic [NT-1:0] seen;
      int  show[2];
      bit  hit[2], tmo[2], acc[2];
      if (r) begin
         m_phase = 0; m_elapsed = 0; m_score = 0; m_misses = 0;
         for (int s = 0; s < 2; s++) begin
            m_armed[s] = 0; m_tgt[s] = 15; m_age[s] = 0; m_prev[s] = -1; m_pulse[s] = 0;
         end
         m_hist.delete();
         m_hist.push_back('0);
         m_hist.push_back('0);
      end else begin
         // photodiode value that has crossed the two synchronizer stages
         seen = m_hist.pop_front();
         m_hist.push_back(ph);
         m_pulse[0] = 0;
         m_pulse[1] = 0;
         if (m_phase != 1) begin
            if (sg) begin
               m_phase = 1; m_elapsed = 0; m_score = 0; m_misses = 0;
               for (int s = 0; s < 2; s++) begin
                  m_armed[s] = 0; m_tgt[s] = 15; m_age[s] = 0; m_prev[s] = -1;
               end
            end
         end else begin
            for (int s = 0; s < 2; s++) begin
               show[s] = m_armed[s] ? m_tgt[s] : 15;
               hit[s]  = m_armed[s] && seen[m_tgt[s]];
               tmo[s]  = m_armed[s] && !hit[s] && (m_age[s] == TO - 1);
            end
            acc[0] = !m_armed[0] && rn < NT && rn != show[1] && rn != m_prev[0];
            acc[1] = !m_armed[1] && rn < NT && rn != show[0] && rn != m_prev[1] && !acc[0];
            for (int s = 0; s < 2; s++) begin
               if (hit[s]) m_score += HP;
               if (tmo[s] && m_misses < 65535) m_misses++;
               m_pulse[s] = hit[s];
               if (acc[s]) begin
                  m_armed[s] = 1; m_tgt[s] = rn; m_age[s] = 0;
               end else if (hit[s] || tmo[s]) begin
                  m_armed[s] = 0; m_prev[s] = m_tgt[s];
               end else if (m_armed[s]) begin
                  m_age[s]++;
               end
            end
            m_elapsed++;
            if (m_elapsed == GC) m_phase = 2;
         end
      end
   endtask

   function automatic snap_t model_view();
      snap_t e;
      e.ta  = 4'(shown(0));
      e.tb  = 4'(shown(1));
      e.sc  = 32'(m_score);
      e.mi  = 16'(m_misses);
      e.act = (m_phase == 1);
      e.ov  = (m_phase == 2);
      e.pa  = m_pulse[0];
      e.pb  = m_pulse[1];
      return e;
   endfunction

   task automatic drive_and_predict(input int c);
      bit            r, sg, dual;
      int            rn;
      logic [NT-1:0] ph;
      r  = (c < 3) || (c == 600);
      sg = (c == 6) || (c == 605) || (c == 1650) || (c == 2700) ||
           (m_phase == 1 && $urandom_range(0, 7) == 0);
      rn = int'($urandom_range(0, 15));
      if (c == 7) rn = 12;
      if (c == 8) rn = 15;
      if (c == 9) rn = 3;
      ph = '0;
      if ($urandom_range(0, 31) == 0) ph[$urandom_range(0, NT - 1)] = 1'b1;
      dual = ($urandom_range(0, 24) == 0);
      for (int s = 0; s < 2; s++) begin
         if (hold_n[s] == 0 && m_phase == 1 && m_armed[s] &&
             (dual || (m_age[s] == TO - 3 && $urandom_range(0, 2) == 0) || $urandom_range(0, 15) == 0)) begin
            hold_n[s] = int'($urandom_range(1, 3));
            hold_i[s] = m_tgt[s];
         end
         if (hold_n[s] > 0) begin
            ph[hold_i[s]] = 1'b1;
            hold_n[s]--;
         end
      end
      reset       = r;
      start_game  = sg;
      rand_num    = 4'(rn);
      photo_array = ph;
      model_edge(r, sg, rn, ph);
      exp_q.push_back(model_view());
      cyc_q.push_back(c);
   endtask

   function automatic string tag(input snap_t e, input int cy);
      if (cy < 3 || cy == 600) return "reset";
      if (e.ov)                return "game_over";
      if (e.pa && e.pb)        return "dual_hit";
      if (e.pa || e.pb)        return "hit";
      if (e.act)               return "run";
      return "idle";
   endfunction

   // Monitor: compares every presented output snapshot against the queued expectation
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            snap_t e, g;
            int    cy;
            e = exp_q.pop_front();
            cy = cyc_q.pop_front();
            g = {target_a, target_b, score, misses, game_active, game_over, hit_pulse_a, hit_pulse_b};
            checks++;
            if (g !== e) begin
               failures++;
               $display("FAIL %s cyc=%0d got ta=%0h tb=%0h score=%0d miss=%0d act=%0b over=%0b pa=%0b pb=%0b required ta=%0h tb=%0h score=%0d miss=%0d act=%0b over=%0b pa=%0b pb=%0b",
                        tag(e, cy), cy, g.ta, g.tb, g.sc, g.mi, g.act, g.ov, g.pa, g.pb,
                        e.ta, e.tb, e.sc, e.mi, e.act, e.ov, e.pa, e.pb);
            end
         end
      end
   end

   initial begin
      hold_n[0] = 0; hold_n[1] = 0; hold_i[0] = 0; hold_i[1] = 0;
      m_phase = 0; m_elapsed = 0; m_score = 0; m_misses = 0;
      for (int s = 0; s < 2; s++) begin
         m_armed[s] = 0; m_tgt[s] = 15; m_age[s] = 0; m_prev[s] = -1; m_pulse[s] = 0;
      end
      m_hist.push_back('0);
      m_hist.push_back('0);
      for (int c = 0; c < NCYC; c++) begin
         if (c > 0) @(negedge clock);
         drive_and_predict(c);
      end
      repeat (2) @(negedge clock);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
